// File: rtl/br_pkg.sv
// br_pkg: shared types and constants for the branch resolver and its prediction queue
//   br_state_e - resolver FSM states (RUN, FLUSH)
//   br_entry_t - one in-flight prediction {pc, pred_taken, pred_pc}
//   ENTRY_W    - packed width of br_entry_t
//   PC_STEP    - sequential instruction size in bytes
package br_pkg;
    typedef enum logic {RUN, FLUSH} br_state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_pc;
    } br_entry_t;
    localparam int ENTRY_W = $bits(br_entry_t);
    localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/pred_fifo.sv
// pred_fifo: in-flight prediction queue, DEPTH entries (power of two, 2..16)
//   clk, reset   - clock, synchronous active-high reset
//   flush        - synchronous empty; wins over a same-cycle push or pop
//   push, din    - write an entry (ignored when full)
//   pop          - drop the head entry (ignored when empty)
//   dout         - current head entry
//   full, empty  - occupancy flags
module pred_fifo
    import br_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic [ENTRY_W-1:0] din,
    input  logic               pop,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty
);
    localparam int AW = $clog2(DEPTH);
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      rd_q, wr_q;
    logic [AW:0]        cnt_q;
    logic               do_push, do_pop;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush) mem_q[wr_q] <= din;
    end
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: matches EX-stage branch resolutions against fetch-time predictions,
// drives the predictor update bus and raises a one-cycle mispredict/redirect.
//   fetch side : f_valid, f_pc, f_pred_taken, f_pred_pc -> f_ready
//   resolve    : r_valid, r_pc, r_is_cond, r_is_jump, r_taken, r_target
//   update bus : update_B_history, update_B_target (pulses), ID_EX_PC, actual_pc, actual_taken
//   redirect   : mispredict (pulse), redirect_pc; q_err is a sticky ordering error
//   optional   : BR_RESOLVER_STATS_EN adds stat_branches, stat_mispred counters
module branch_resolver
    import br_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_valid,
    input  logic [31:0] f_pc,
    input  logic        f_pred_taken,
    input  logic [31:0] f_pred_pc,
    output logic        f_ready,
    input  logic        r_valid,
    input  logic [31:0] r_pc,
    input  logic        r_is_cond,
    input  logic        r_is_jump,
    input  logic        r_taken,
    input  logic [31:0] r_target,
    output logic        update_B_history,
    output logic        update_B_target,
    output logic [31:0] ID_EX_PC,
    output logic [31:0] actual_pc,
    output logic        actual_taken,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        q_err
`ifdef BR_RESOLVER_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
`endif
);
    br_state_e          state_q, state_d;
    br_entry_t          head, entry_in;
    logic [ENTRY_W-1:0] head_raw;
    logic               full, empty, res, bad, mis, unused;
    logic [31:0]        actual_next;
    logic               hist_q, btgt_q, atk_q, mis_q, err_q;
    logic [31:0]        idex_q, apc_q, redir_q;

    assign entry_in    = '{pc: f_pc, pred_taken: f_pred_taken, pred_pc: f_pred_pc};
    assign head        = head_raw;
    assign unused      = head.pred_taken;
    assign f_ready     = !full && state_q == RUN;
    assign res         = r_valid && state_q == RUN;
    // an out-of-order resolve never consumes the head, so the queue stays intact for debug
    assign bad         = empty || head.pc != r_pc;
    assign actual_next = r_taken ? r_target : r_pc + PC_STEP;
    assign mis         = res && !bad && head.pred_pc != actual_next;
    assign state_d     = state_q == FLUSH ? RUN : (mis ? FLUSH : RUN);

    // flush beats push, so a fetch issued alongside the mispredicting resolve is dropped
    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .reset(reset),
        .flush(mis),
        .push (f_valid && f_ready),
        .din  (entry_in),
        .pop  (res && !bad),
        .dout (head_raw),
        .full (full),
        .empty(empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            hist_q  <= 1'b0;
            btgt_q  <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            atk_q   <= 1'b0;
            idex_q  <= '0;
            apc_q   <= '0;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= res && r_is_cond;
            btgt_q  <= res && (r_is_cond || r_is_jump) && r_taken;
            mis_q   <= mis;
            if (res && bad) err_q <= 1'b1;
            if (mis) redir_q <= actual_next;
            if (res) begin
                idex_q <= r_pc;
                apc_q  <= r_target;
                atk_q  <= r_taken;
            end
        end
    end

    assign update_B_history = hist_q;
    assign update_B_target  = btgt_q;
    assign ID_EX_PC         = idex_q;
    assign actual_pc        = apc_q;
    assign actual_taken     = atk_q;
    assign mispredict       = mis_q;
    assign redirect_pc      = redir_q;
    assign q_err            = err_q;

`ifdef BR_RESOLVER_STATS_EN
    logic [31:0] nbr_q, nmis_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            nbr_q  <= '0;
            nmis_q <= '0;
        end else begin
            if (res && (r_is_cond || r_is_jump)) nbr_q <= nbr_q + 32'd1;
            if (mis) nmis_q <= nmis_q + 32'd1;
        end
    end
    assign stat_branches = nbr_q;
    assign stat_mispred  = nmis_q;
`endif
endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;
    localparam bit T = 1'b1, F = 1'b0;

    logic        clk = 1'b0, reset;
    logic        f_valid, f_pred_taken, f_ready;
    logic [31:0] f_pc, f_pred_pc;
    logic        r_valid, r_is_cond, r_is_jump, r_taken;
    logic [31:0] r_pc, r_target;
    logic        update_B_history, update_B_target, actual_taken, mispredict, q_err;
    logic [31:0] ID_EX_PC, actual_pc, redirect_pc;
`ifdef BR_RESOLVER_STATS_EN
    logic [31:0] stat_branches, stat_mispred;
`endif

    branch_resolver #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .f_valid(f_valid), .f_pc(f_pc), .f_pred_taken(f_pred_taken), .f_pred_pc(f_pred_pc),
        .f_ready(f_ready),
        .r_valid(r_valid), .r_pc(r_pc), .r_is_cond(r_is_cond), .r_is_jump(r_is_jump),
        .r_taken(r_taken), .r_target(r_target),
        .update_B_history(update_B_history), .update_B_target(update_B_target),
        .ID_EX_PC(ID_EX_PC), .actual_pc(actual_pc), .actual_taken(actual_taken),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .q_err(q_err)
`ifdef BR_RESOLVER_STATS_EN
        , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic fv; logic [31:0] fpc; logic fpt; logic [31:0] fppc;
        logic rv; logic [31:0] rpc; logic c, j, t; logic [31:0] tg;
        logic bus;
        logic hist, btgt, mis; logic [31:0] redir, idex, apc; logic atk, qerr, frdy;
    } vec_t;

    vec_t v[18];
    vec_t sb[$];
    vec_t e;
    int n_vec = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] fpc, input logic fpt, input logic [31:0] fppc,
                         input logic rv, input logic [31:0] rpc, input logic c, input logic j,
                         input logic t, input logic [31:0] tg);
        f_valid = fv; f_pc = fpc; f_pred_taken = fpt; f_pred_pc = fppc;
        r_valid = rv; r_pc = rpc; r_is_cond = c; r_is_jump = j; r_taken = t; r_target = tg;
    endtask

    task automatic idle();
        drive(F, 0, F, 0, F, 0, F, F, F, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hist"}, update_B_history, 0);
        chk({tag, "_btgt"}, update_B_target, 0);
        chk({tag, "_idex"}, ID_EX_PC, 0);
        chk({tag, "_apc"}, actual_pc, 0);
        chk({tag, "_atk"}, actual_taken, 0);
        chk({tag, "_mis"}, mispredict, 0);
        chk({tag, "_redir"}, redirect_pc, 0);
        chk({tag, "_qerr"}, q_err, 0);
        chk({tag, "_frdy"}, f_ready, 1);
`ifdef BR_RESOLVER_STATS_EN
        chk({tag, "_stat_br"}, stat_branches, 0);
        chk({tag, "_stat_mis"}, stat_mispred, 0);
`endif
    endtask

    initial begin
        //        fv fpc           fpt fppc        rv rpc           c  j  t  tg          bus hist btgt mis redir      idex          apc       atk qerr frdy
        v[0]  = '{T, 32'h100,      F, 32'h104,    F, 0,            F, F, F, 0,          T,  F,   F,   F,  0,         0,            0,        F,  F,   T};
        v[1]  = '{F, 0,            F, 0,          T, 32'h100,      T, F, F, 32'h200,    T,  T,   F,   F,  0,         32'h100,      32'h200,  F,  F,   T};
        v[2]  = '{T, 32'h200,      F, 32'h204,    F, 0,            F, F, F, 0,          T,  F,   F,   F,  0,         32'h100,      32'h200,  F,  F,   T};
        v[3]  = '{T, 32'h208,      F, 32'h20C,    T, 32'h200,      T, F, T, 32'h180,    T,  T,   T,   T,  32'h180,   32'h200,      32'h180,  T,  F,   F};
        v[4]  = '{T, 32'h300,      F, 32'h304,    T, 32'h208,      T, F, T, 32'h999,    T,  F,   F,   F,  32'h180,   32'h200,      32'h180,  T,  F,   T};
        v[5]  = '{T, 32'h300,      T, 32'h304,    F, 0,            F, F, F, 0,          T,  F,   F,   F,  32'h180,   32'h200,      32'h180,  T,  F,   T};
        v[6]  = '{F, 0,            F, 0,          T, 32'h300,      F, T, T, 32'h304,    T,  F,   T,   F,  32'h180,   32'h300,      32'h304,  T,  F,   T};
        v[7]  = '{T, 32'hFFFFFFFC, F, 32'h0,      F, 0,            F, F, F, 0,          T,  F,   F,   F,  32'h180,   32'h300,      32'h304,  T,  F,   T};
        v[8]  = '{F, 0,            F, 0,          T, 32'hFFFFFFFC, T, F, F, 32'h40,     T,  T,   F,   F,  32'h180,   32'hFFFFFFFC, 32'h40,   F,  F,   T};
        v[9]  = '{T, 32'h400,      F, 32'h404,    F, 0,            F, F, F, 0,          T,  F,   F,   F,  32'h180,   32'hFFFFFFFC, 32'h40,   F,  F,   T};
        v[10] = '{T, 32'h404,      F, 32'h408,    F, 0,            F, F, F, 0,          T,  F,   F,   F,  32'h180,   32'hFFFFFFFC, 32'h40,   F,  F,   T};
        v[11] = '{T, 32'h408,      F, 32'h40C,    F, 0,            F, F, F, 0,          T,  F,   F,   F,  32'h180,   32'hFFFFFFFC, 32'h40,   F,  F,   T};
        v[12] = '{T, 32'h40C,      F, 32'h410,    F, 0,            F, F, F, 0,          T,  F,   F,   F,  32'h180,   32'hFFFFFFFC, 32'h40,   F,  F,   F};
        v[13] = '{T, 32'h410,      F, 32'h414,    T, 32'h400,      T, F, F, 32'h0,      T,  T,   F,   F,  32'h180,   32'h400,      32'h0,    F,  F,   T};
        v[14] = '{F, 0,            F, 0,          T, 32'h404,      T, F, F, 32'h0,      T,  T,   F,   F,  32'h180,   32'h404,      32'h0,    F,  F,   T};
        v[15] = '{F, 0,            F, 0,          T, 32'h408,      T, F, F, 32'h0,      T,  T,   F,   F,  32'h180,   32'h408,      32'h0,    F,  F,   T};
        v[16] = '{F, 0,            F, 0,          T, 32'h40C,      T, F, F, 32'h0,      T,  T,   F,   F,  32'h180,   32'h40C,      32'h0,    F,  F,   T};
        v[17] = '{F, 0,            F, 0,          T, 32'h410,      T, F, F, 32'h0,      F,  F,   F,   F,  0,         0,            0,        F,  T,   T};

        reset = 1'b1;
        idle();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(v[i].fv, v[i].fpc, v[i].fpt, v[i].fppc, v[i].rv, v[i].rpc, v[i].c, v[i].j, v[i].t, v[i].tg);
            sb.push_back(v[i]);
            tick();
            e = sb.pop_front();
            if (e.bus) begin
                chk($sformatf("v%0d_hist", i), update_B_history, e.hist);
                chk($sformatf("v%0d_btgt", i), update_B_target, e.btgt);
                chk($sformatf("v%0d_mis", i), mispredict, e.mis);
                chk($sformatf("v%0d_redir", i), redirect_pc, e.redir);
                chk($sformatf("v%0d_idex", i), ID_EX_PC, e.idex);
                chk($sformatf("v%0d_apc", i), actual_pc, e.apc);
                chk($sformatf("v%0d_atk", i), actual_taken, e.atk);
            end
            chk($sformatf("v%0d_qerr", i), q_err, e.qerr);
            chk($sformatf("v%0d_frdy", i), f_ready, e.frdy);
        end
        idle();
        tick();
        chk("empty_err_held", q_err, 1);

        reset = 1'b1;
        drive(F, 0, F, 0, T, 32'h123, T, F, F, 0);
        tick();
        reset = 1'b0;
        chk("rst_ovr_qerr", q_err, 0);
        chk("rst_ovr_hist", update_B_history, 0);
        drive(T, 32'h304, F, 32'h308, F, 0, F, F, F, 0);
        tick();
        drive(F, 0, F, 0, T, 32'h300, T, F, F, 0);
        tick();
        chk("order_err", q_err, 1);
        idle();
        repeat (3) tick();
        chk("order_err_sticky", q_err, 1);

        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(T, 32'h500 + 32'(4 * k), F, 32'h504 + 32'(4 * k), F, 0, F, F, F, 0);
            tick();
        end
        chk("fill_frdy", f_ready, 0);
        drive(F, 0, F, 0, T, 32'h500, T, F, T, 32'h700);
        tick();
        chk("flush_mis", mispredict, 1);
        chk("flush_redir", redirect_pc, 32'h700);
        chk("flush_frdy", f_ready, 0);
`ifdef BR_RESOLVER_STATS_EN
        chk("stat_br_cnt", stat_branches, 1);
        chk("stat_mis_cnt", stat_mispred, 1);
`endif
        reset = 1'b1;
        drive(T, 32'h600, F, 32'h604, T, 32'h504, T, F, F, 0);
        tick();
        reset = 1'b0;
        chk_all_zero("rst_flush");
        drive(F, 0, F, 0, T, 32'h504, T, F, F, 0);
        tick();
        chk("post_rst_empty", q_err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
